// File: rtl/axi_dac_jesd204_upack_if.sv
// rtl/axi_dac_jesd204_upack_if.sv - DMA beat stream into the JESD204 DAC unpacker
interface axi_dac_jesd204_upack_if #(
    parameter int NUM_CHANNELS    = 4,
    parameter int DATA_PATH_WIDTH = 4
);
    logic                                       s_axis_valid;
    logic                                       s_axis_ready;
    logic [NUM_CHANNELS*DATA_PATH_WIDTH*16-1:0] s_axis_data;

    modport master (
        output s_axis_valid,
        output s_axis_data,
        input  s_axis_ready
    );

    modport slave (
        input  s_axis_valid,
        input  s_axis_data,
        output s_axis_ready
    );
endinterface

// File: rtl/axi_dac_jesd204_upack.sv
// rtl/axi_dac_jesd204_upack.sv - unpacks enabled-channel DMA beats into fixed per-channel DAC slots
module axi_dac_jesd204_upack #(
    parameter int NUM_CHANNELS    = 4,
    parameter int DATA_PATH_WIDTH = 4
) (
    input  logic                                       dac_clk,
    input  logic                                       dac_rst,
    input  logic [NUM_CHANNELS-1:0]                    dac_enable,
    input  logic [NUM_CHANNELS-1:0]                    dac_valid,
    output logic [NUM_CHANNELS*DATA_PATH_WIDTH*16-1:0] dac_ddata,
    output logic                                       dac_dunf,
    axi_dac_jesd204_upack_if.slave                     s_axis
);
    localparam int W   = NUM_CHANNELS * DATA_PATH_WIDTH;
    localparam int CDW = 16 * DATA_PATH_WIDTH;
    localparam int DW  = W * 16;
    localparam int CW  = $clog2(NUM_CHANNELS + 1);
    localparam int KW  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int IW  = (W > 1) ? $clog2(W) : 1;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [15:0]     beat_q [W];
    logic [NUM_CHANNELS-1:0] mask_q;
    logic [CW-1:0]   e_cnt, e_q;
    logic [KW-1:0]   s_last, s_last_q;
    logic            cfg_ok;
    logic            advance;
    logic            last_slice;
    logic            accept;
    logic [DW-1:0]   slice_data;
    int              rank;
    int              idx;

    // Only bit 0 of dac_valid paces the block; the rest are deliberately ignored.
    logic unused_valid_bits;
    assign unused_valid_bits = ^{1'b0, dac_valid};

    assign advance    = dac_valid[0];
    assign last_slice = (state_q == ST_FULL) && (k_q == s_last_q);

    // Ready looks only at state, enables and the advance strobe, never at s_axis_valid.
    assign s_axis.s_axis_ready = ~dac_rst & cfg_ok &
                                 ((state_q == ST_EMPTY) | (last_slice & advance));
    assign accept = s_axis.s_axis_valid & s_axis.s_axis_ready;

    // Count enabled channels, check for a power of two, derive the last slice index.
    always_comb begin
        e_cnt  = '0;
        s_last = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            e_cnt = e_cnt + CW'(dac_enable[c]);
        end
        cfg_ok = (e_cnt != '0) && ((e_cnt & (e_cnt - CW'(1))) == '0);
        for (int i = 0; i <= $clog2(NUM_CHANNELS); i++) begin
            if (e_cnt == CW'(1 << i)) begin
                s_last = KW'((NUM_CHANNELS >> i) - 1);
            end
        end
    end

    // Beat buffer next state: load on accept, otherwise walk slices on advance.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        if (accept) begin
            state_d = ST_FULL;
            k_d     = '0;
        end else if ((state_q == ST_FULL) && advance) begin
            if (last_slice) begin
                state_d = ST_EMPTY;
                k_d     = '0;
            end else begin
                k_d = k_q + KW'(1);
            end
        end
    end

    // Buffer state and slice counter.
    always_ff @(posedge dac_clk) begin
        if (dac_rst) begin
            state_q <= ST_EMPTY;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // Latch the channel layout with each beat so enable changes never disturb a beat in flight.
    always_ff @(posedge dac_clk) begin
        if (dac_rst) begin
            mask_q   <= '0;
            e_q      <= '0;
            s_last_q <= '0;
        end else if (accept) begin
            mask_q   <= dac_enable;
            e_q      <= e_cnt;
            s_last_q <= s_last;
        end
    end

    // Beat payload; contents are don't-care while the buffer is empty.
    always_ff @(posedge dac_clk) begin
        if (accept) begin
            for (int w = 0; w < W; w++) begin
                beat_q[w] <= s_axis.s_axis_data[16*w +: 16];
            end
        end
    end

    // Gather the current slice: enabled channel of rank e takes word k*E*DPW + s*E + e.
    always_comb begin
        slice_data = '0;
        rank       = 0;
        idx        = 0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (mask_q[c]) begin
                for (int s = 0; s < DATA_PATH_WIDTH; s++) begin
                    idx = int'(k_q) * int'(e_q) * DATA_PATH_WIDTH + s * int'(e_q) + rank;
                    slice_data[c*CDW + s*16 +: 16] = beat_q[IW'(idx)];
                end
                rank = rank + 1;
            end
        end
    end

    // Output register: moves only on advance; an empty buffer yields zeros and underrun.
    always_ff @(posedge dac_clk) begin
        if (dac_rst) begin
            dac_ddata <= '0;
            dac_dunf  <= 1'b0;
        end else if (advance) begin
            if (state_q == ST_FULL) begin
                dac_ddata <= slice_data;
                dac_dunf  <= 1'b0;
            end else begin
                dac_ddata <= '0;
                dac_dunf  <= 1'b1;
            end
        end
    end
endmodule
